// File: rtl/inst_rom_loader.sv
// Instruction ROM for the OpenMIPS core, filled at boot from a valid/ready byte
// stream (length, big-endian words, XOR checksum); holds the core in reset until a good image lands.
module inst_rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        cpu_rst_o,
  output logic        ld_done_o,
  output logic        ld_err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [16:0] MAX_WORDS = 17'(DEPTH);
  localparam logic [DEPTH_LOG2:0] WCNT_ONE = (DEPTH_LOG2+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]          len_hi;
  logic [15:0]         n_words;
  logic [DEPTH_LOG2:0] word_cnt;
  logic [1:0]          byte_cnt;
  logic [23:0]         word_buf;
  logic [7:0]          xor_acc;
  logic [31:0]         mem [DEPTH];

  logic        accept;
  logic        wr_en;
  logic [16:0] len_rx;
  logic [16:0] words_done;
  logic        unused_addr_bits;

  // ld_ready depends on state alone, so accept never loops back through it
  assign ld_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);
  assign accept     = ld_valid & ld_ready;
  assign len_rx     = {1'b0, len_hi, ld_byte};
  assign words_done = 17'(word_cnt) + 17'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_rst_o = 1'b1;
    ld_done_o = 1'b0;
    ld_err_o  = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: ;
      S_LEN_HI: begin
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (len_rx == 17'd0)          state_nxt = S_CSUM;
          else if (len_rx > MAX_WORDS)  state_nxt = S_ERR;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3)) begin
          wr_en = 1'b1;
          if (words_done == {1'b0, n_words}) state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_nxt = (ld_byte == xor_acc) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        cpu_rst_o = 1'b0;
        ld_done_o = 1'b1;
      end
      S_ERR: begin
        ld_err_o = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A restart overrides any byte arriving on the same edge
    if (ld_start) begin
      state_nxt = S_LEN_HI;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi   <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      xor_acc  <= '0;
    end else if (ld_start) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      xor_acc  <= '0;
    end else if (accept) begin
      case (state)
        S_LEN_HI: len_hi  <= ld_byte;
        S_LEN_LO: n_words <= {len_hi, ld_byte};
        S_DATA: begin
          byte_cnt <= byte_cnt + 2'd1;
          xor_acc  <= xor_acc ^ ld_byte;
          word_buf <= {word_buf[15:0], ld_byte};
          if (byte_cnt == 2'd3) word_cnt <= word_cnt + WCNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[word_cnt[DEPTH_LOG2-1:0]] <= {word_buf, ld_byte};
  end

  assign rom_data_o = (rom_ce_i && (state == S_RUN)) ? mem[rom_addr_i[DEPTH_LOG2+1:2]] : '0;

  // Byte offset and high address bits do not select a word; addresses wrap
  assign unused_addr_bits = ^{rom_addr_i[31:DEPTH_LOG2+2], rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed + randomized bench for inst_rom_loader; image contents and checksums
// come from a word-array reference of the instruction memory.
module tb_inst_rom_loader;

  localparam int unsigned DL    = 10;
  localparam int unsigned DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        cpu_rst_o;
  logic        ld_done_o;
  logic        ld_err_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] img [DEPTH];
  bit          exp_run = 1'b0;

  always #5 clk = ~clk;

  inst_rom_loader #(.DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .cpu_rst_o  (cpu_rst_o),
    .ld_done_o  (ld_done_o),
    .ld_err_o   (ld_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    check("ld_ready_for_byte", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_byte  = 8'($urandom);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    ld_valid = 1'b0;
    tick();
    ld_start = 1'b0;
    exp_run  = 1'b0;
    check("ready_after_start", {31'd0, ld_ready}, 32'd1);
    check("cpu_rst_after_start", {31'd0, cpu_rst_o}, 32'd1);
  endtask

  task automatic check_state(input bit run, input bit err);
    check("cpu_rst_o", {31'd0, cpu_rst_o}, {31'd0, ~run});
    check("ld_done_o", {31'd0, ld_done_o}, {31'd0, run});
    check("ld_err_o",  {31'd0, ld_err_o},  {31'd0, err});
    check("ld_ready_final", {31'd0, ld_ready}, 32'd0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom;
  endtask

  // Sends LEN, the first n words of img, then the XOR checksum (corrupted if bad)
  task automatic load_image(input int n, input bit bad, input bit do_start);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    logic [15:0] n16;
    x   = 8'd0;
    n16 = n[15:0];
    if (do_start) pulse_start();
    check("cpu_rst_loading", {31'd0, cpu_rst_o}, 32'd1);
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
        b = w[31-8*j -: 8];
        x = x ^ b;
        send_byte(b);
      end
      ref_mem[i] = w;
    end
    b = bad ? (x ^ 8'h01) : x;
    send_byte(b);
    exp_run = !bad;
    check_state(!bad, bad);
  endtask

  task automatic read_addr(input logic [31:0] addr, input logic [31:0] exp);
    rom_addr_i = addr;
    #2;
    check("rom_data_o", rom_data_o, exp);
    tick();
  endtask

  task automatic read_idx(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[11:2] = idx[9:0];
    read_addr(a, exp_run ? ref_mem[idx] : 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_byte    = 8'd0;
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'd0;

    #2;
    check("reset_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    check("reset_ready",   {31'd0, ld_ready},  32'd0);
    check("reset_done",    {31'd0, ld_done_o}, 32'd0);
    check("reset_err",     {31'd0, ld_err_o},  32'd0);
    check("reset_data",    rom_data_o,         32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Idle after reset: bytes are refused until a start pulse
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      tick();
      check("idle_ready", {31'd0, ld_ready}, 32'd0);
      check("idle_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    end
    ld_valid = 1'b0;

    // Two-word reference image
    img[0] = 32'h3401_0005;
    img[1] = 32'h3402_0007;
    load_image(2, 1'b0, 1'b1);
    read_addr(32'h0000_0000, 32'h3401_0005);
    read_addr(32'h0000_0004, 32'h3402_0007);
    read_addr(32'h0000_1004, 32'h3402_0007);
    read_addr(32'h0000_0007, 32'h3402_0007);
    rom_ce_i = 1'b0;
    read_addr(32'h0000_0000, 32'd0);
    rom_ce_i = 1'b1;

    // Same image, wrong checksum
    load_image(2, 1'b1, 1'b1);
    read_addr(32'h0000_0000, 32'd0);
    read_addr(32'h0000_0004, 32'd0);

    // Empty image: straight to checksum, old contents retained
    load_image(0, 1'b0, 1'b1);
    read_addr(32'h0000_0000, 32'h3401_0005);
    read_addr(32'h0000_0004, 32'h3402_0007);

    // Oversized length is rejected at the second length byte
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h01);
    exp_run = 1'b0;
    check_state(1'b0, 1'b1);

    // Full-depth image
    fill_random(DEPTH);
    load_image(DEPTH, 1'b0, 1'b1);
    read_idx(0);
    read_idx(DEPTH - 1);
    for (int i = 0; i < 6; i++) read_idx($urandom_range(0, DEPTH - 1));

    // Restart coinciding with a valid byte in the middle of DATA
    fill_random(8);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h08);
    for (int j = 0; j < 4; j++) send_byte(img[0][31-8*j -: 8]);
    send_byte(img[1][31:24]);
    send_byte(img[1][23:16]);
    ref_mem[0] = img[0];
    ld_valid = 1'b1;
    ld_byte  = 8'($urandom);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    check("abort_ready", {31'd0, ld_ready}, 32'd1);
    check("abort_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    check("abort_done", {31'd0, ld_done_o}, 32'd0);
    fill_random(3);
    load_image(3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) read_idx(i);

    // Asynchronous reset in the middle of DATA
    fill_random(4);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int j = 0; j < 4; j++) send_byte(img[0][31-8*j -: 8]);
    send_byte(img[1][31:24]);
    ref_mem[0] = img[0];
    ld_valid = 1'($urandom_range(0, 1));
    ld_byte  = 8'($urandom);
    #2;
    rst = 1'b0;
    #1;
    exp_run = 1'b0;
    check("async_rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    check("async_rst_ready",   {31'd0, ld_ready},  32'd0);
    check("async_rst_done",    {31'd0, ld_done_o}, 32'd0);
    check("async_rst_err",     {31'd0, ld_err_o},  32'd0);
    check("async_rst_data",    rom_data_o,         32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      ld_valid = 1'($urandom_range(0, 1));
      ld_byte  = 8'($urandom);
      check("in_rst_ready", {31'd0, ld_ready}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_byte  = 8'($urandom);
      tick();
      check("post_rst_ready", {31'd0, ld_ready}, 32'd0);
      check("post_rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    end
    ld_valid = 1'b0;
    fill_random(5);
    load_image(5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) read_idx(i);

    // Random images, some with corrupted checksums
    for (int t = 0; t < 5; t++) begin
      int  n;
      bit  bad;
      n   = $urandom_range(1, 40);
      bad = ($urandom_range(0, 2) == 0);
      fill_random(n);
      load_image(n, bad, 1'b1);
      read_idx(n - 1);
      for (int i = 0; i < 5; i++) read_idx($urandom_range(0, DEPTH - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
